// File: rtl/wb_stage_grf.sv
// wb_stage_grf: MIPS writeback stage with the 32x32 general register file.
// Define GRF_BYPASS_EN to forward the pending write straight to both read ports.
module wb_stage_grf #(
    parameter int          NREG      = 32,
    parameter logic [31:0] RESET_PC8 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_w,
    input  logic [31:0] pc8_w,
    input  logic [31:0] ao_w,
    input  logic [31:0] dr_w,
    input  logic [31:0] hi_w,
    input  logic [31:0] lo_w,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        SRC_AO, SRC_PC8, SRC_HI, SRC_LO, SRC_MEM
    } src_e;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic        wr;
    logic [4:0]  dst;
    src_e        src;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] mem_data;
    logic [31:0] rf_q [NREG];
    logic [31:0] retire_q;
    logic [31:0] retire_d;
    logic [31:0] rs_raw;
    logic [31:0] rt_raw;
    logic        unused_ok;

    assign op = ir_w[31:26];
    assign fn = ir_w[5:0];

    // RESET_PC8 is kept only so traces line up with the fetch side.
    assign unused_ok = ^RESET_PC8;

    always_comb begin
        wr  = 1'b0;
        dst = ir_w[15:11];
        src = SRC_AO;
        unique case (op)
            6'h00: begin
                unique case (fn)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04,
                    6'h06, 6'h07: wr = 1'b1;
                    6'h10: begin wr = 1'b1; src = SRC_HI;  end
                    6'h12: begin wr = 1'b1; src = SRC_LO;  end
                    6'h09: begin wr = 1'b1; src = SRC_PC8; end
                    default: wr = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                wr  = 1'b1;
                dst = ir_w[20:16];
            end
            6'h03: begin
                wr  = 1'b1;
                dst = 5'd31;
                src = SRC_PC8;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                wr  = 1'b1;
                dst = ir_w[20:16];
                src = SRC_MEM;
            end
            default: wr = 1'b0;
        endcase
    end

    assign ld_b = dr_w[{ao_w[1:0], 3'b000} +: 8];
    assign ld_h = ao_w[1] ? dr_w[31:16] : dr_w[15:0];

    always_comb begin
        mem_data = dr_w;
        unique case (op)
            6'h20:   mem_data = {{24{ld_b[7]}}, ld_b};
            6'h24:   mem_data = {24'h0, ld_b};
            6'h21:   mem_data = {{16{ld_h[15]}}, ld_h};
            6'h25:   mem_data = {16'h0, ld_h};
            default: mem_data = dr_w;
        endcase
    end

    always_comb begin
        wb_data = ao_w;
        unique case (src)
            SRC_PC8: wb_data = pc8_w;
            SRC_HI:  wb_data = hi_w;
            SRC_LO:  wb_data = lo_w;
            SRC_MEM: wb_data = mem_data;
            default: wb_data = ao_w;
        endcase
    end

    assign wb_addr  = dst;
    assign wb_en    = wr && (dst != 5'd0);
    assign retire_d = (ir_w != 32'h0) ? retire_q + 32'd1 : retire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= 32'h0;
            end
            retire_q <= 32'h0;
        end else begin
            if (wb_en) begin
                rf_q[wb_addr] <= wb_data;
            end
            retire_q <= retire_d;
        end
    end

    assign rs_raw = (rs_addr == 5'd0) ? 32'h0 : rf_q[rs_addr];
    assign rt_raw = (rt_addr == 5'd0) ? 32'h0 : rf_q[rt_addr];

`ifdef GRF_BYPASS_EN
    // wb_en is already false for $0, so $0 can never be forwarded.
    assign rs_data = (wb_en && rs_addr == wb_addr) ? wb_data : rs_raw;
    assign rt_data = (wb_en && rt_addr == wb_addr) ? wb_data : rt_raw;
`else
    assign rs_data = rs_raw;
    assign rt_data = rt_raw;
`endif

    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage_grf.sv
// tb_wb_stage_grf: vector table, directed corner cases and random traffic
// for wb_stage_grf, checked against a behavioural register-file model.
module tb_wb_stage_grf;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_w, pc8_w, ao_w, dr_w, hi_w, lo_w;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, retire_cnt;
    logic        wb_en;
    logic [4:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_ret;

    wb_stage_grf dut (
        .clk(clk), .reset(reset),
        .ir_w(ir_w), .pc8_w(pc8_w), .ao_w(ao_w), .dr_w(dr_w),
        .hi_w(hi_w), .lo_w(lo_w),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the instruction should write, straight from the ISA rules.
    function automatic void model_wb(
        input  logic [31:0] ir, pc8, ao, dr, hi, lo,
        output bit en, output logic [4:0] a, output logic [31:0] d);
        bit   [5:0]  op;
        bit   [5:0]  fn;
        logic [31:0] byt;
        logic [31:0] hw;
        op  = ir[31:26];
        fn  = ir[5:0];
        byt = (dr >> (8 * ao[1:0])) & 32'hFF;
        hw  = (dr >> (16 * ao[1])) & 32'hFFFF;
        en  = 1'b0;
        a   = 5'd0;
        d   = 32'h0;
        if (op == 0 && fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04,
                6'h06, 6'h07}) begin
            en = 1; a = ir[15:11]; d = ao;
        end else if (op == 0 && fn == 6'h10) begin
            en = 1; a = ir[15:11]; d = hi;
        end else if (op == 0 && fn == 6'h12) begin
            en = 1; a = ir[15:11]; d = lo;
        end else if (op == 0 && fn == 6'h09) begin
            en = 1; a = ir[15:11]; d = pc8;
        end else if (op inside {[6'h08:6'h0f]}) begin
            en = 1; a = ir[20:16]; d = ao;
        end else if (op == 6'h03) begin
            en = 1; a = 5'd31; d = pc8;
        end else if (op == 6'h23) begin
            en = 1; a = ir[20:16]; d = dr;
        end else if (op == 6'h20) begin
            en = 1; a = ir[20:16];
            d = byt[7] ? (byt | 32'hFFFF_FF00) : byt;
        end else if (op == 6'h24) begin
            en = 1; a = ir[20:16]; d = byt;
        end else if (op == 6'h21) begin
            en = 1; a = ir[20:16];
            d = hw[15] ? (hw | 32'hFFFF_0000) : hw;
        end else if (op == 6'h25) begin
            en = 1; a = ir[20:16]; d = hw;
        end
        if (a == 0) en = 1'b0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] ra,
        input bit en, input logic [4:0] a, input logic [31:0] d);
        if (ra == 0) return 32'h0;
        if (BYP && en && ra == a) return d;
        return m_rf[ra];
    endfunction

    // One cycle with the current inputs: check outputs, update model, clock.
    task automatic run_cycle();
        bit          en;
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        model_wb(ir_w, pc8_w, ao_w, dr_w, hi_w, lo_w, en, a, d);
        chk("wb_en", {31'h0, wb_en}, {31'h0, en});
        if (en) begin
            chk("wb_addr", {27'h0, wb_addr}, {27'h0, a});
            chk("wb_data", wb_data, d);
        end
        chk("rs_data", rs_data, model_rd(rs_addr, en, a, d));
        chk("rt_data", rt_data, model_rd(rt_addr, en, a, d));
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_ret = 32'h0;
        end else begin
            if (en) m_rf[a] = d;
            if (ir_w != 0) m_ret = m_ret + 1;
        end
        @(posedge clk);
        #1;
        chk("retire_cnt", retire_cnt, m_ret);
    endtask

    typedef struct {
        logic [31:0] ir, pc8, ao, hi, lo;
        bit          en;
        logic [4:0]  a;
        logic [31:0] d;
        bit          chk_ad;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] saved;
    bit   [5:0]  ops [22] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a,
        6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h03, 6'h20, 6'h21, 6'h23,
        6'h24, 6'h25, 6'h2b, 6'h28, 6'h04, 6'h02, 6'h3f};
    bit   [5:0]  fns [23] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10,
        6'h12, 6'h09, 6'h08, 6'h18, 6'h1a, 6'h11, 6'h13, 6'h3f};

    initial begin
        tbl[0]  = '{32'h3401_1234, 0, 32'h1234, 0, 0, 1, 1,  32'h0000_1234, 1};
        tbl[1]  = '{32'h8002_0000, 0, 32'h3, 0, 0, 1, 2,  32'hFFFF_FF80, 1};
        tbl[2]  = '{32'h9002_0000, 0, 32'h2, 0, 0, 1, 2,  32'h0000_00FF, 1};
        tbl[3]  = '{32'h8402_0000, 0, 32'h2, 0, 0, 1, 2,  32'hFFFF_80FF, 1};
        tbl[4]  = '{32'h9402_0000, 0, 32'h0, 0, 0, 1, 2,  32'h0000_7F01, 1};
        tbl[5]  = '{32'h0C00_0000, 32'h3010, 0, 0, 0, 1, 31, 32'h0000_3010, 1};
        tbl[6]  = '{32'h0000_1810, 0, 0, 32'hDEAD_BEEF, 0, 1, 3, 32'hDEAD_BEEF, 1};
        tbl[7]  = '{32'h0021_0021, 0, 32'h5, 0, 0, 0, 0,  32'h0000_0005, 1};
        tbl[8]  = '{32'h0000_2812, 0, 0, 0, 32'hCAFE_F00D, 1, 5, 32'hCAFE_F00D, 1};
        tbl[9]  = '{32'h0000_3009, 32'h4008, 0, 0, 0, 1, 6, 32'h0000_4008, 1};
        tbl[10] = '{32'hAC02_0000, 0, 32'h10, 0, 0, 0, 0, 32'h0, 0};
        tbl[11] = '{32'h8C07_0000, 0, 32'h0, 0, 0, 1, 7,  32'h80FF_7F01, 1};
        tbl[12] = '{32'h8408_0000, 0, 32'h3, 0, 0, 1, 8,  32'hFFFF_80FF, 1};
        tbl[13] = '{32'h8009_0000, 0, 32'h1, 0, 0, 1, 9,  32'h0000_007F, 1};

        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_ret   = 32'h0;
        reset   = 1'b1;
        ir_w    = 0; pc8_w = 0; ao_w = 0; dr_w = 0; hi_w = 0; lo_w = 0;
        rs_addr = 0; rt_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk("reset_rs", rs_data, 32'h0);
            chk("reset_rt", rt_data, 32'h0);
        end
        chk("reset_retire", retire_cnt, 32'h0);

        dr_w = 32'h80FF_7F01;
        for (int i = 0; i < 14; i++) begin
            ir_w  = tbl[i].ir;  pc8_w = tbl[i].pc8; ao_w = tbl[i].ao;
            hi_w  = tbl[i].hi;  lo_w  = tbl[i].lo;
            rs_addr = 0; rt_addr = 0;
            #1;
            chk("vec_en", {31'h0, wb_en}, {31'h0, tbl[i].en});
            if (tbl[i].chk_ad) begin
                chk("vec_addr", {27'h0, wb_addr}, {27'h0, tbl[i].a});
                chk("vec_data", wb_data, tbl[i].d);
            end
            run_cycle();
            ir_w    = 0;
            rs_addr = tbl[i].a;
            rt_addr = tbl[i].a;
            #1;
            if (tbl[i].chk_ad) begin
                chk("vec_readback", rs_data, tbl[i].en ? tbl[i].d : 32'h0);
                chk("vec_readback_rt", rt_data, tbl[i].en ? tbl[i].d : 32'h0);
            end
        end

        saved = m_ret;
        ir_w  = 0;
        repeat (3) run_cycle();
        chk("nop_retire_hold", retire_cnt, saved);

        ir_w = 32'h3404_0001; ao_w = 32'h1;
        rs_addr = 4; rt_addr = 0;
        run_cycle();
        ir_w = 32'h3404_0000; ao_w = 32'h2;
        rs_addr = 4; rt_addr = 4;
        #1;
        chk("bypass_rs", rs_data, BYP ? 32'h2 : 32'h1);
        chk("bypass_rt", rt_data, BYP ? 32'h2 : 32'h1);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        ir_w  = 0;
        #1;
        chk("reset_kills_write", rs_data, 32'h0);
        chk("reset_retire_clr", retire_cnt, 32'h0);

        for (int n = 0; n < 400; n++) begin
            bit [5:0] op;
            op    = ops[$urandom_range(0, 21)];
            ir_w  = {op, 26'($urandom)};
            if (op == 0) ir_w[5:0] = fns[$urandom_range(0, 22)];
            if ($urandom_range(0, 9) == 0) ir_w = 32'h0;
            pc8_w = $urandom; ao_w = $urandom; dr_w = $urandom;
            hi_w  = $urandom; lo_w = $urandom;
            rs_addr = 5'($urandom);
            rt_addr = 5'($urandom);
            if ($urandom_range(0, 2) == 0) rs_addr = ir_w[15:11];
            if ($urandom_range(0, 2) == 0) rt_addr = ir_w[20:16];
            reset = ($urandom_range(0, 49) == 0);
            run_cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
